// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared constants, state types and helpers for the 4-bit HD44780 driver
package lcd_pkg;

  localparam logic [7:0] FUNC_SET  = 8'h28;
  localparam logic [7:0] DISP_ON   = 8'h0C;
  localparam logic [7:0] ENTRY     = 8'h06;
  localparam logic [7:0] CLEAR     = 8'h01;
  localparam logic [7:0] LINE1     = 8'h80;
  localparam logic [7:0] LINE2     = 8'hC0;
  localparam logic [3:0] INIT_NIB  = 4'h3;
  localparam logic [3:0] MODE4_NIB = 4'h2;

  // Default timings in clock cycles at 100 MHz
  localparam int unsigned T_POWERUP_DEF = 2_000_000;
  localparam int unsigned T_INIT1_DEF   = 410_000;
  localparam int unsigned T_INIT2_DEF   = 10_000;
  localparam int unsigned T_ENABLE_DEF  = 25;
  localparam int unsigned T_NIBBLE_DEF  = 100;
  localparam int unsigned T_CMD_DEF     = 4_000;
  localparam int unsigned T_CLEAR_DEF   = 164_000;

  typedef enum logic [3:0] {
    PWRUP, INIT_A, INIT_B, INIT_C, INIT_D, CFG, ADDR_A, ROW_A, ADDR_B, ROW_B
  } lcd_state_e;

  typedef enum logic [2:0] {
    W_IDLE, W_SETUP, W_HIGH, W_HOLD, W_GAP, W_WAIT
  } wr_state_e;

  function automatic logic [7:0] cfg_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    return FUNC_SET;
      2'd1:    return DISP_ON;
      2'd2:    return ENTRY;
      default: return CLEAR;
    endcase
  endfunction

  // Column 0 lives in the top byte of a row string
  function automatic logic [7:0] char_at(input logic [127:0] row, input logic [3:0] col);
    logic [127:0] shifted;
    shifted = row << {col, 3'b000};
    return shifted[127:120];
  endfunction

endpackage

// File: rtl/lcd_nibble_writer.sv
// rtl/lcd_nibble_writer.sv - strobes one nibble or one byte onto the LCD bus, then idles for wait_cycles_i
module lcd_nibble_writer
  import lcd_pkg::*;
#(
  parameter int unsigned T_ENABLE = T_ENABLE_DEF,
  parameter int unsigned T_NIBBLE = T_NIBBLE_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        rs_i,
  input  logic [7:0]  byte_i,
  input  logic        nibble_only_i,
  input  logic [31:0] wait_cycles_i,
  output logic        lcd_e_o,
  output logic        lcd_rs_o,
  output logic [3:0]  lcd_d_o,
  output logic        done_o
);

  wr_state_e   state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] wait_q, wait_d;
  logic [7:0]  byte_q, byte_d;
  logic        nib_only_q, nib_only_d;
  logic        low_q, low_d;
  logic        e_q, rs_q, rs_d;
  logic [3:0]  d_q, d_d;

  // Kept apart from the next-state logic so done never depends on start
  assign done_o = (state_q == W_HOLD && (nib_only_q || low_q) && wait_q == 32'd0) ||
                  (state_q == W_WAIT && cnt_q == 32'd0);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wait_d     = wait_q;
    byte_d     = byte_q;
    nib_only_d = nib_only_q;
    low_d      = low_q;
    rs_d       = rs_q;
    d_d        = d_q;
    case (state_q)
      W_IDLE: state_d = W_IDLE;
      W_SETUP: begin
        if (T_ENABLE == 0) begin
          state_d = W_HOLD;
        end else begin
          state_d = W_HIGH;
          cnt_d   = 32'(T_ENABLE - 1);
        end
      end
      W_HIGH: begin
        if (cnt_q == 32'd0) state_d = W_HOLD;
        else                cnt_d   = cnt_q - 32'd1;
      end
      W_HOLD: begin
        if (!nib_only_q && !low_q) begin
          low_d = 1'b1;
          if (T_NIBBLE == 0) begin
            state_d = W_SETUP;
            d_d     = byte_q[3:0];
          end else begin
            state_d = W_GAP;
            cnt_d   = 32'(T_NIBBLE - 1);
          end
        end else if (wait_q == 32'd0) begin
          state_d = W_IDLE;
        end else begin
          state_d = W_WAIT;
          cnt_d   = wait_q - 32'd1;
        end
      end
      W_GAP: begin
        if (cnt_q == 32'd0) begin
          state_d = W_SETUP;
          d_d     = byte_q[3:0];
        end else begin
          cnt_d = cnt_q - 32'd1;
        end
      end
      W_WAIT: begin
        if (cnt_q == 32'd0) state_d = W_IDLE;
        else                cnt_d   = cnt_q - 32'd1;
      end
      default: state_d = W_IDLE;
    endcase
    if ((state_q == W_IDLE || done_o) && start_i) begin
      state_d    = W_SETUP;
      byte_d     = byte_i;
      nib_only_d = nibble_only_i;
      wait_d     = wait_cycles_i;
      rs_d       = rs_i;
      low_d      = 1'b0;
      d_d        = nibble_only_i ? byte_i[3:0] : byte_i[7:4];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= W_IDLE;
      cnt_q      <= '0;
      wait_q     <= '0;
      byte_q     <= '0;
      nib_only_q <= 1'b0;
      low_q      <= 1'b0;
      e_q        <= 1'b0;
      rs_q       <= 1'b0;
      d_q        <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wait_q     <= wait_d;
      byte_q     <= byte_d;
      nib_only_q <= nib_only_d;
      low_q      <= low_d;
      e_q        <= (state_d == W_HIGH);
      rs_q       <= rs_d;
      d_q        <= d_d;
    end
  end

  assign lcd_e_o  = e_q;
  assign lcd_rs_o = rs_q;
  assign lcd_d_o  = d_q;

endmodule

// File: rtl/lcd_module_4bit.sv
// rtl/lcd_module_4bit.sv - 1602 LCD driver: power-up init, then endless refresh of both rows
module lcd_module_4bit
  import lcd_pkg::*;
#(
  parameter int unsigned T_POWERUP = T_POWERUP_DEF,
  parameter int unsigned T_INIT1   = T_INIT1_DEF,
  parameter int unsigned T_INIT2   = T_INIT2_DEF,
  parameter int unsigned T_ENABLE  = T_ENABLE_DEF,
  parameter int unsigned T_NIBBLE  = T_NIBBLE_DEF,
  parameter int unsigned T_CMD     = T_CMD_DEF,
  parameter int unsigned T_CLEAR   = T_CLEAR_DEF
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [127:0] row_A,
  input  logic [127:0] row_B,
  output logic         LCD_E,
  output logic         LCD_RS,
  output logic         LCD_RW,
  output logic [3:0]   LCD_D
);

  lcd_state_e   state_q, state_d;
  logic [31:0]  cnt_q, cnt_d;
  logic [3:0]   idx_q, idx_d;
  logic [127:0] shadow_a_q, shadow_a_d;
  logic [127:0] shadow_b_q, shadow_b_d;

  logic         wr_start, wr_done;
  logic         item_rs, item_nib;
  logic [7:0]   item_byte;
  logic [31:0]  item_wait;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shadow_a_d = shadow_a_q;
    shadow_b_d = shadow_b_q;
    wr_start   = 1'b0;
    if (state_q == PWRUP) begin
      if (cnt_q + 32'd1 >= T_POWERUP) begin
        state_d  = INIT_A;
        wr_start = 1'b1;
      end else begin
        cnt_d = cnt_q + 32'd1;
      end
    end else if (wr_done) begin
      // Next item is launched in the same cycle the previous one finishes
      wr_start = 1'b1;
      case (state_q)
        INIT_A: state_d = INIT_B;
        INIT_B: state_d = INIT_C;
        INIT_C: state_d = INIT_D;
        INIT_D: begin state_d = CFG; idx_d = 4'd0; end
        CFG: begin
          if (idx_q == 4'd3) begin state_d = ADDR_A; idx_d = 4'd0; end
          else               idx_d = idx_q + 4'd1;
        end
        ADDR_A: begin state_d = ROW_A; idx_d = 4'd0; end
        ROW_A: begin
          if (idx_q == 4'd15) begin state_d = ADDR_B; idx_d = 4'd0; end
          else                idx_d = idx_q + 4'd1;
        end
        ADDR_B: begin state_d = ROW_B; idx_d = 4'd0; end
        ROW_B: begin
          if (idx_q == 4'd15) begin state_d = ADDR_A; idx_d = 4'd0; end
          else                idx_d = idx_q + 4'd1;
        end
        default: state_d = PWRUP;
      endcase
    end
    if (state_d == ADDR_A && state_q != ADDR_A) begin
      shadow_a_d = row_A;
      shadow_b_d = row_B;
    end
  end

  always_comb begin
    item_rs   = 1'b0;
    item_nib  = 1'b0;
    item_byte = 8'h00;
    item_wait = 32'(T_CMD);
    case (state_d)
      INIT_A: begin item_nib = 1'b1; item_byte = {4'h0, INIT_NIB};  item_wait = 32'(T_INIT1); end
      INIT_B: begin item_nib = 1'b1; item_byte = {4'h0, INIT_NIB};  item_wait = 32'(T_INIT2); end
      INIT_C: begin item_nib = 1'b1; item_byte = {4'h0, INIT_NIB};  end
      INIT_D: begin item_nib = 1'b1; item_byte = {4'h0, MODE4_NIB}; end
      CFG:    item_byte = cfg_byte(idx_d[1:0]);
      ADDR_A: item_byte = LINE1;
      ADDR_B: item_byte = LINE2;
      ROW_A:  begin item_rs = 1'b1; item_byte = char_at(shadow_a_q, idx_d); end
      ROW_B:  begin item_rs = 1'b1; item_byte = char_at(shadow_b_q, idx_d); end
      default: item_byte = 8'h00;
    endcase
    if (!item_rs && !item_nib && item_byte == CLEAR) item_wait = 32'(T_CLEAR);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= PWRUP;
      cnt_q      <= '0;
      idx_q      <= '0;
      shadow_a_q <= '0;
      shadow_b_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shadow_a_q <= shadow_a_d;
      shadow_b_q <= shadow_b_d;
    end
  end

  lcd_nibble_writer #(
    .T_ENABLE (T_ENABLE),
    .T_NIBBLE (T_NIBBLE)
  ) u_writer (
    .clk           (clk),
    .rst           (reset),
    .start_i       (wr_start),
    .rs_i          (item_rs),
    .byte_i        (item_byte),
    .nibble_only_i (item_nib),
    .wait_cycles_i (item_wait),
    .lcd_e_o       (LCD_E),
    .lcd_rs_o      (LCD_RS),
    .lcd_d_o       (LCD_D),
    .done_o        (wr_done)
  );

  assign LCD_RW = 1'b0;

endmodule

// File: tb/tb_lcd_module_4bit.sv
// tb/tb_lcd_module_4bit.sv - directed bench: init, frames, mid-frame row change, async reset
module tb_lcd_module_4bit;

  localparam int T_POWERUP = 10;
  localparam int T_INIT1   = 8;
  localparam int T_INIT2   = 4;
  localparam int T_ENABLE  = 2;
  localparam int T_NIBBLE  = 3;
  localparam int T_CMD     = 5;
  localparam int T_CLEAR   = 7;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] row_a, row_b;
  logic         lcd_e, lcd_rs, lcd_rw;
  logic [3:0]   lcd_d;

  lcd_module_4bit #(
    .T_POWERUP (T_POWERUP), .T_INIT1 (T_INIT1), .T_INIT2 (T_INIT2),
    .T_ENABLE  (T_ENABLE),  .T_NIBBLE (T_NIBBLE), .T_CMD (T_CMD), .T_CLEAR (T_CLEAR)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .row_A  (row_a),
    .row_B  (row_b),
    .LCD_E  (lcd_e),
    .LCD_RS (lcd_rs),
    .LCD_RW (lcd_rw),
    .LCD_D  (lcd_d)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Cycle index since reset release; outputs after posedge k are seen with cyc == k
  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc = reset ? 0 : cyc + 1;
  end

  int         nrise, nfall, rw_bad;
  int         rise_cyc [256];
  logic [3:0] rise_nib [256];
  int         fall_cyc [256];
  logic [4:0] fall_v   [256];
  logic       e_prev;

  initial begin
    nrise = 0; nfall = 0; rw_bad = 0; e_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (lcd_rw !== 1'b0) rw_bad++;
      if (reset) begin
        nrise = 0; nfall = 0; e_prev = 1'b0;
      end else begin
        if (lcd_e && !e_prev && nrise < 256) begin
          rise_cyc[nrise] = cyc; rise_nib[nrise] = lcd_d; nrise++;
        end
        if (!lcd_e && e_prev && nfall < 256) begin
          fall_cyc[nfall] = cyc; fall_v[nfall] = {lcd_rs, lcd_d}; nfall++;
        end
        e_prev = lcd_e;
      end
    end
  end

  // Expected nibble stream: {rs, nibble} and the E-low gap until the next rise
  logic [4:0] exp_v   [256];
  int         exp_gap [256];
  int         n_exp = 0;

  task automatic push_nib(input logic rs, input logic [3:0] nib, input int wait_cyc);
    exp_v[n_exp]   = {rs, nib};
    exp_gap[n_exp] = wait_cyc + 2;   // hold cycle + idle cycles + setup cycle
    n_exp++;
  endtask

  task automatic push_byte(input logic rs, input logic [7:0] b);
    push_nib(rs, b[7:4], T_NIBBLE);
    push_nib(rs, b[3:0], (!rs && b == 8'h01) ? T_CLEAR : T_CMD);
  endtask

  task automatic push_row(input logic [127:0] row);
    logic [127:0] t;
    for (int n = 0; n < 16; n++) begin
      t = row >> (8 * (15 - n));
      push_byte(1'b1, t[7:0]);
    end
  endtask

  task automatic wait_falls(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (nfall < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, 32'(nfall >= n), 32'd1);
  endtask

  task automatic check_stream(input int n, input string pfx);
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_nib%0d", pfx, i), 32'(fall_v[i]), 32'(exp_v[i]));
      check($sformatf("%s_width%0d", pfx, i), 32'(fall_cyc[i] - rise_cyc[i]), 32'(T_ENABLE));
      if (i < n - 1)
        check($sformatf("%s_gap%0d", pfx, i), 32'(rise_cyc[i + 1] - fall_cyc[i]), 32'(exp_gap[i]));
    end
  endtask

  localparam logic [127:0] HELLO = "HELLO WORLD 1234";
  localparam logic [127:0] ALPHA = "ABCDEFGHIJKLMNOP";
  localparam logic [127:0] HASH  = {16{8'h23}};

  initial begin
    int k;
    reset = 1'b1;
    row_a = HELLO;
    row_b = ALPHA;

    push_nib(1'b0, 4'h3, T_INIT1);
    push_nib(1'b0, 4'h3, T_INIT2);
    push_nib(1'b0, 4'h3, T_CMD);
    push_nib(1'b0, 4'h2, T_CMD);
    push_byte(1'b0, 8'h28);
    push_byte(1'b0, 8'h0C);
    push_byte(1'b0, 8'h06);
    push_byte(1'b0, 8'h01);
    push_byte(1'b0, 8'h80);
    push_row(HELLO);
    push_byte(1'b0, 8'hC0);
    push_row(ALPHA);
    push_byte(1'b0, 8'h80);
    push_row(HASH);
    push_byte(1'b0, 8'hC0);
    push_row(ALPHA);
    push_byte(1'b0, 8'h80);

    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("rst_out%0d", i), {27'd0, lcd_e, lcd_rs, lcd_rw, lcd_d}, 32'd0);
    end
    reset = 1'b0;
    #1 check("release_out", {27'd0, lcd_e, lcd_rs, lcd_rw, lcd_d}, 32'd0);

    // Column 4 of ROW_A is nibbles 22/23 of the stream
    k = 0;
    while (nrise < 23 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    check("reach_col4", 32'(nrise >= 23), 32'd1);
    row_a = HASH;

    wait_falls(n_exp, 6000, "frames_done");
    check("first_rise_cyc", 32'(rise_cyc[0]), 32'd11);
    check("first_rise_d", {28'd0, rise_nib[0]}, 32'h3);
    check_stream(n_exp, "run1");
    check("rw_never_high", 32'(rw_bad), 32'd0);

    k = 0;
    while (lcd_e !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("found_e_high", {31'd0, lcd_e}, 32'd1);
    #2 reset = 1'b1;
    #1 check("async_e_drop", {27'd0, lcd_e, lcd_rs, lcd_rw, lcd_d}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("rst2_out%0d", i), {27'd0, lcd_e, lcd_rs, lcd_rw, lcd_d}, 32'd0);
    end
    reset = 1'b0;

    wait_falls(5, 500, "restart_done");
    check("restart_rise_cyc", 32'(rise_cyc[0]), 32'd11);
    check("restart_rise_d", {28'd0, rise_nib[0]}, 32'h3);
    check_stream(5, "run2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
